// File: rtl/alu_exec_unit_pkg.sv
// Shared encodings for the ALU execute stage: alu_op classes, funct fields and
// the 5-bit alu_ctrl operation codes, plus the control decode function.
package alu_exec_unit_pkg;

    localparam int unsigned WIDTH_FIXED = 32;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_RTYPE = 2'b10,
        ALUOP_OR    = 2'b11
    } alu_op_e;

    typedef enum logic [4:0] {
        ALU_ADD  = 5'd0,
        ALU_ADDU = 5'd1,
        ALU_SUB  = 5'd2,
        ALU_SUBU = 5'd3,
        ALU_AND  = 5'd4,
        ALU_OR   = 5'd5,
        ALU_XOR  = 5'd6,
        ALU_NOR  = 5'd7,
        ALU_SLT  = 5'd8,
        ALU_SLTU = 5'd9,
        ALU_SLL  = 5'd10,
        ALU_SRL  = 5'd11,
        ALU_SRA  = 5'd12,
        ALU_SLLV = 5'd13,
        ALU_SRLV = 5'd14,
        ALU_SRAV = 5'd15
    } alu_ctrl_e;

    localparam logic [5:0] FUNCT_SLL  = 6'h00;
    localparam logic [5:0] FUNCT_SRL  = 6'h02;
    localparam logic [5:0] FUNCT_SRA  = 6'h03;
    localparam logic [5:0] FUNCT_SLLV = 6'h04;
    localparam logic [5:0] FUNCT_SRLV = 6'h06;
    localparam logic [5:0] FUNCT_SRAV = 6'h07;
    localparam logic [5:0] FUNCT_JR   = 6'h08;
    localparam logic [5:0] FUNCT_ADD  = 6'h20;
    localparam logic [5:0] FUNCT_ADDU = 6'h21;
    localparam logic [5:0] FUNCT_SUB  = 6'h22;
    localparam logic [5:0] FUNCT_SUBU = 6'h23;
    localparam logic [5:0] FUNCT_AND  = 6'h24;
    localparam logic [5:0] FUNCT_OR   = 6'h25;
    localparam logic [5:0] FUNCT_XOR  = 6'h26;
    localparam logic [5:0] FUNCT_NOR  = 6'h27;
    localparam logic [5:0] FUNCT_SLT  = 6'h2A;
    localparam logic [5:0] FUNCT_SLTU = 6'h2B;

    typedef struct packed {
        logic [4:0] alu_ctrl;
        logic       jump_register;
    } decode_t;

    // jr is executed as ADD so the register value flows through unchanged logic.
    function automatic decode_t decode_ctrl(input logic [1:0] alu_op, input logic [5:0] funct);
        decode_t d;
        d.alu_ctrl      = ALU_ADD;
        d.jump_register = 1'b0;
        case (alu_op)
            ALUOP_ADD: d.alu_ctrl = ALU_ADD;
            ALUOP_SUB: d.alu_ctrl = ALU_SUB;
            ALUOP_OR:  d.alu_ctrl = ALU_OR;
            ALUOP_RTYPE: begin
                case (funct)
                    FUNCT_ADD:  d.alu_ctrl = ALU_ADD;
                    FUNCT_ADDU: d.alu_ctrl = ALU_ADDU;
                    FUNCT_SUB:  d.alu_ctrl = ALU_SUB;
                    FUNCT_SUBU: d.alu_ctrl = ALU_SUBU;
                    FUNCT_AND:  d.alu_ctrl = ALU_AND;
                    FUNCT_OR:   d.alu_ctrl = ALU_OR;
                    FUNCT_XOR:  d.alu_ctrl = ALU_XOR;
                    FUNCT_NOR:  d.alu_ctrl = ALU_NOR;
                    FUNCT_SLT:  d.alu_ctrl = ALU_SLT;
                    FUNCT_SLTU: d.alu_ctrl = ALU_SLTU;
                    FUNCT_SLL:  d.alu_ctrl = ALU_SLL;
                    FUNCT_SRL:  d.alu_ctrl = ALU_SRL;
                    FUNCT_SRA:  d.alu_ctrl = ALU_SRA;
                    FUNCT_SLLV: d.alu_ctrl = ALU_SLLV;
                    FUNCT_SRLV: d.alu_ctrl = ALU_SRLV;
                    FUNCT_SRAV: d.alu_ctrl = ALU_SRAV;
                    FUNCT_JR: begin
                        d.alu_ctrl      = ALU_ADD;
                        d.jump_register = 1'b1;
                    end
                    default: d.alu_ctrl = ALU_ADD;
                endcase
            end
            default: d.alu_ctrl = ALU_ADD;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/alu_exec_unit_alu_core.sv
// Purely combinational ALU datapath: arithmetic, logic, compares and shifts
// selected by the decoded 5-bit alu_ctrl code.
module alu_core
    import alu_exec_unit_pkg::*;
(
    input  logic [4:0]  alu_ctrl,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic [4:0]  shamt,
    output logic [31:0] result
);

    logic [4:0] var_sh_s;
    assign var_sh_s = src_a[4:0];

    // Operation select; signed and unsigned add/sub share the same wrapping adder.
    always_comb begin
        result = 32'd0;
        case (alu_ctrl)
            ALU_ADD, ALU_ADDU: result = src_a + src_b;
            ALU_SUB, ALU_SUBU: result = src_a - src_b;
            ALU_AND:  result = src_a & src_b;
            ALU_OR:   result = src_a | src_b;
            ALU_XOR:  result = src_a ^ src_b;
            ALU_NOR:  result = ~(src_a | src_b);
            ALU_SLT:  result = {31'd0, ($signed(src_a) < $signed(src_b))};
            ALU_SLTU: result = {31'd0, (src_a < src_b)};
            ALU_SLL:  result = src_b << shamt;
            ALU_SRL:  result = src_b >> shamt;
            ALU_SRA:  result = $unsigned($signed(src_b) >>> shamt);
            ALU_SLLV: result = src_b << var_sh_s;
            ALU_SRLV: result = src_b >> var_sh_s;
            ALU_SRAV: result = $unsigned($signed(src_b) >>> var_sh_s);
            default:  result = 32'd0;
        endcase
    end

endmodule

// File: rtl/alu_exec_unit.sv
// Execute stage: control decode, ALU, PC incrementer and branch-target adder,
// with every output registered one cycle after the inputs.
module alu_exec_unit
    import alu_exec_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        alu_op,
    input  logic [5:0]        funct,
    input  logic [4:0]        shamt,
    input  logic [WIDTH-1:0]  src_a,
    input  logic [WIDTH-1:0]  src_b,
    input  logic [WIDTH-1:0]  pc,
    input  logic [15:0]       imm,
    output logic [4:0]        alu_ctrl,
    output logic              jump_register,
    output logic [WIDTH-1:0]  alu_result,
    output logic              zero,
    output logic [WIDTH-1:0]  pc_plus4,
    output logic [WIDTH-1:0]  branch_target
);

    decode_t     dec_s;
    logic [31:0] result_s;
    logic [31:0] pc_plus4_s;
    logic [31:0] branch_off_s;
    logic [31:0] branch_target_s;

    assign dec_s           = decode_ctrl(alu_op, funct);
    assign pc_plus4_s      = pc + 32'd4;
    assign branch_off_s    = {{14{imm[15]}}, imm, 2'b00};
    assign branch_target_s = pc_plus4_s + branch_off_s;

    alu_core u_alu_core (
        .alu_ctrl (dec_s.alu_ctrl),
        .src_a    (src_a),
        .src_b    (src_b),
        .shamt    (shamt),
        .result   (result_s)
    );

    // Output register; zero is taken from the same-cycle result so it aligns with alu_result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_ctrl      <= 5'd0;
            jump_register <= 1'b0;
            alu_result    <= 32'd0;
            zero          <= 1'b0;
            pc_plus4      <= 32'd0;
            branch_target <= 32'd0;
        end else begin
            alu_ctrl      <= dec_s.alu_ctrl;
            jump_register <= dec_s.jump_register;
            alu_result    <= result_s;
            zero          <= (result_s == 32'd0);
            pc_plus4      <= pc_plus4_s;
            branch_target <= branch_target_s;
        end
    end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed self-checking bench for alu_exec_unit with hand-computed expectations.
module tb_alu_exec_unit;

    logic        clk;
    logic        rst_n;
    logic [1:0]  alu_op;
    logic [5:0]  funct;
    logic [4:0]  shamt;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic [31:0] pc;
    logic [15:0] imm;
    logic [4:0]  alu_ctrl;
    logic        jump_register;
    logic [31:0] alu_result;
    logic        zero;
    logic [31:0] pc_plus4;
    logic [31:0] branch_target;

    int n_checks = 0;
    int n_fail   = 0;

    alu_exec_unit #(.WIDTH(32)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .alu_op        (alu_op),
        .funct         (funct),
        .shamt         (shamt),
        .src_a         (src_a),
        .src_b         (src_b),
        .pc            (pc),
        .imm           (imm),
        .alu_ctrl      (alu_ctrl),
        .jump_register (jump_register),
        .alu_result    (alu_result),
        .zero          (zero),
        .pc_plus4      (pc_plus4),
        .branch_target (branch_target)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [1:0] op, input logic [5:0] fn, input logic [4:0] sh,
                         input logic [31:0] a, input logic [31:0] b);
        alu_op = op; funct = fn; shamt = sh; src_a = a; src_b = b;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic alu_case(input string tag, input logic [1:0] op, input logic [5:0] fn,
                            input logic [4:0] sh, input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] exp_res, input logic [4:0] exp_ctrl,
                            input logic exp_jr);
        drive(op, fn, sh, a, b);
        step();
        check({tag, "_result"}, alu_result, exp_res);
        check({tag, "_zero"}, {31'd0, zero}, {31'd0, (exp_res == 32'd0)});
        check({tag, "_ctrl"}, {27'd0, alu_ctrl}, {27'd0, exp_ctrl});
        check({tag, "_jr"}, {31'd0, jump_register}, {31'd0, exp_jr});
    endtask

    initial begin
        rst_n = 1'b0;
        drive(2'b10, 6'h20, 5'd3, 32'h1111_1111, 32'h2222_2222);
        pc = 32'h0000_1000; imm = 16'h0001;
        step();
        step();
        check("reset_result", alu_result, 32'd0);
        check("reset_ctrl", {27'd0, alu_ctrl}, 32'd0);
        check("reset_pc4", pc_plus4, 32'd0);
        check("reset_bt", branch_target, 32'd0);
        check("reset_zero", {31'd0, zero}, 32'd0);

        rst_n = 1'b1;
        step();
        check("first_load_result", alu_result, 32'h3333_3333);
        check("first_load_pc4", pc_plus4, 32'h0000_1004);
        check("first_load_bt", branch_target, 32'h0000_1008);

        alu_case("add_ovf",  2'b10, 6'h20, 5'd0, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 5'd0, 1'b0);
        alu_case("beq_sub",  2'b01, 6'h00, 5'd0, 32'h1234_5678, 32'h1234_5678, 32'h0000_0000, 5'd2, 1'b0);
        alu_case("slt",      2'b10, 6'h2A, 5'd0, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 5'd8, 1'b0);
        alu_case("sltu",     2'b10, 6'h2B, 5'd0, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 5'd9, 1'b0);
        alu_case("sra4",     2'b10, 6'h03, 5'd4, 32'h0000_0000, 32'h8000_0000, 32'hF800_0000, 5'd12, 1'b0);
        alu_case("sra0",     2'b10, 6'h03, 5'd0, 32'h0000_0000, 32'h8000_0001, 32'h8000_0001, 5'd12, 1'b0);
        alu_case("jr",       2'b10, 6'h08, 5'd0, 32'h0000_0005, 32'h0000_0006, 32'h0000_000B, 5'd0, 1'b1);
        alu_case("lw_jrfn",  2'b00, 6'h08, 5'd0, 32'h0000_0005, 32'h0000_0006, 32'h0000_000B, 5'd0, 1'b0);
        alu_case("ori",      2'b11, 6'h08, 5'd0, 32'hF0F0_0000, 32'h0000_FFFF, 32'hF0F0_FFFF, 5'd5, 1'b0);
        alu_case("nor",      2'b10, 6'h27, 5'd0, 32'h0F0F_0F0F, 32'h00FF_00FF, 32'hF000_F000, 5'd7, 1'b0);
        alu_case("xor",      2'b10, 6'h26, 5'd0, 32'hFFFF_0000, 32'h0FF0_0FF0, 32'hF00F_0FF0, 5'd6, 1'b0);
        alu_case("and",      2'b10, 6'h24, 5'd0, 32'hFFFF_0000, 32'h0FF0_0FF0, 32'h0FF0_0000, 5'd4, 1'b0);
        alu_case("or",       2'b10, 6'h25, 5'd0, 32'h0000_00F0, 32'h0000_000F, 32'h0000_00FF, 5'd5, 1'b0);
        alu_case("srl8",     2'b10, 6'h02, 5'd8, 32'h0000_0000, 32'h8000_0000, 32'h0080_0000, 5'd11, 1'b0);
        alu_case("sll4",     2'b10, 6'h00, 5'd4, 32'h0000_0000, 32'h0000_000F, 32'h0000_00F0, 5'd10, 1'b0);
        alu_case("srav",     2'b10, 6'h07, 5'd9, 32'h0000_0021, 32'h8000_0000, 32'hC000_0000, 5'd15, 1'b0);
        alu_case("srlv",     2'b10, 6'h06, 5'd0, 32'h0000_0003, 32'h0000_00F0, 32'h0000_001E, 5'd14, 1'b0);
        alu_case("sllv",     2'b10, 6'h04, 5'd0, 32'h0000_0024, 32'h0000_0001, 32'h0000_0010, 5'd13, 1'b0);
        alu_case("subu",     2'b10, 6'h23, 5'd0, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 5'd3, 1'b0);
        alu_case("sub",      2'b10, 6'h22, 5'd0, 32'h0000_0010, 32'h0000_0003, 32'h0000_000D, 5'd2, 1'b0);
        alu_case("addu_wrap",2'b10, 6'h21, 5'd0, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 5'd1, 1'b0);
        alu_case("unlisted", 2'b10, 6'h3F, 5'd0, 32'h0000_0100, 32'h0000_0023, 32'h0000_0123, 5'd0, 1'b0);

        pc = 32'h0000_0100; imm = 16'hFFFF;
        step();
        check("pc4_0x100", pc_plus4, 32'h0000_0104);
        check("bt_back", branch_target, 32'h0000_0100);
        pc = 32'hFFFF_FFFC; imm = 16'h0004;
        step();
        check("pc4_wrap", pc_plus4, 32'h0000_0000);
        check("bt_wrap", branch_target, 32'h0000_0010);
        pc = 32'h0000_2000; imm = 16'h8000;
        step();
        check("bt_min", branch_target, 32'hFFFE_2004);

        // Register holds between edges: new inputs must not show before the next edge.
        drive(2'b10, 6'h20, 5'd0, 32'h0000_0001, 32'h0000_0002);
        step();
        check("hold_pre", alu_result, 32'h0000_0003);
        @(negedge clk);
        drive(2'b10, 6'h20, 5'd0, 32'h0000_0010, 32'h0000_0020);
        #1;
        check("hold_mid", alu_result, 32'h0000_0003);
        step();
        check("hold_post", alu_result, 32'h0000_0030);

        // Asynchronous reset between edges with nonzero outputs.
        drive(2'b10, 6'h08, 5'd0, 32'h0000_0040, 32'h0000_0001);
        step();
        check("pre_rst_jr", {31'd0, jump_register}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_result", alu_result, 32'd0);
        check("async_jr", {31'd0, jump_register}, 32'd0);
        check("async_pc4", pc_plus4, 32'd0);
        check("async_bt", branch_target, 32'd0);
        check("async_ctrl", {27'd0, alu_ctrl}, 32'd0);
        check("async_zero", {31'd0, zero}, 32'd0);
        step();
        check("rst_hold_result", alu_result, 32'd0);
        drive(2'b10, 6'h2A, 5'd0, 32'h8000_0000, 32'h0000_0000);
        rst_n = 1'b1;
        step();
        check("post_rst_result", alu_result, 32'h0000_0001);
        check("post_rst_ctrl", {27'd0, alu_ctrl}, 32'd8);
        check("post_rst_pc4", pc_plus4, 32'h0000_2004);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
